ili9341_parallel_8bit_rx: RTL and testbench

- Device-side model of the ILI9341 8080-style 8-bit parallel bus. It is the responder on the same bus the LCD host driver drives, covering LCD_RST/CS/RS/WR/RD and D[7:0].
- Decodes command and parameter bytes, tracks the CASET/PASET address window, and turns RAMWR RGB565 byte pairs into a coordinate-tagged pixel stream.
- Used in FPGA loopback tests and simulation, where it stands in for the panel so that VPU output can be checked or captured.

---
 rtl/ili9341_parallel_8bit_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_ili9341_parallel_8bit_rx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_parallel_8bit_rx.sv
// Responder for the ILI9341 8080-style 8-bit write bus: decodes commands, tracks the
// CASET/PASET window and turns RAMWR RGB565 byte pairs into a coordinate-tagged pixel stream.
module ili9341_parallel_8bit_rx #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_rst_n,
    input  logic        lcd_cs_n,
    input  logic        lcd_rs,
    input  logic        lcd_wr_n,
    input  logic        lcd_rd_n,
    input  logic [7:0]  lcd_d,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_rgb565,
    output logic        frame_done
);
    localparam logic [15:0] EC_RST = 16'(WIDTH - 1);
    localparam logic [15:0] EP_RST = 16'(HEIGHT - 1);
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    typedef enum logic [2:0] {
        S_IDLE, S_CASET, S_PASET, S_SKIP, S_RAMWR_HI, S_RAMWR_LO
    } state_t;

    logic [1:0]  cs_sync_q, rs_sync_q, wr_sync_q, lrst_sync_q;
    logic [7:0]  d_meta_q, d_sync_q;
    logic        wr_prev_q;
    logic        stb_q, stb_rs_q;
    logic [7:0]  stb_d_q;
    logic        strobe;
    logic        rd_unused;

    // Read strobes are accepted on the pin but have no effect.
    assign rd_unused = lcd_rd_n;
    assign strobe    = wr_sync_q[1] & ~wr_prev_q & ~cs_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= 2'b11;
            rs_sync_q   <= 2'b00;
            wr_sync_q   <= 2'b11;
            lrst_sync_q <= 2'b00;
            d_meta_q    <= 8'h00;
            d_sync_q    <= 8'h00;
            wr_prev_q   <= 1'b1;
            stb_q       <= 1'b0;
            stb_rs_q    <= 1'b0;
            stb_d_q     <= 8'h00;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], lcd_cs_n};
            rs_sync_q   <= {rs_sync_q[0], lcd_rs};
            wr_sync_q   <= {wr_sync_q[0], lcd_wr_n};
            lrst_sync_q <= {lrst_sync_q[0], lcd_rst_n};
            d_meta_q    <= lcd_d;
            d_sync_q    <= d_meta_q;
            wr_prev_q   <= wr_sync_q[1];
            stb_q       <= strobe & lrst_sync_q[1];
            stb_rs_q    <= rs_sync_q[1];
            stb_d_q     <= d_sync_q;
        end
    end

    state_t      state_q, state_d;
    logic [1:0]  pidx_q, pidx_d;
    logic [23:0] par_q, par_d;
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [7:0]  hi_q, hi_d;
    logic        cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_rgb_q, pix_rgb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pidx_q       <= 2'd0;
            par_q        <= 24'h0;
            sc_q         <= 16'h0;
            ec_q         <= EC_RST;
            sp_q         <= 16'h0;
            ep_q         <= EP_RST;
            x_q          <= 16'h0;
            y_q          <= 16'h0;
            hi_q         <= 8'h00;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'h00;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= 16'h0;
            pix_y_q      <= 16'h0;
            pix_rgb_q    <= 16'h0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pidx_q       <= pidx_d;
            par_q        <= par_d;
            sc_q         <= sc_d;
            ec_q         <= ec_d;
            sp_q         <= sp_d;
            ep_q         <= ep_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hi_q         <= hi_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pidx_d       = pidx_q;
        par_d        = par_q;
        sc_d         = sc_q;
        ec_d         = ec_q;
        sp_d         = sp_q;
        ep_d         = ep_q;
        x_d          = x_q;
        y_d          = y_q;
        hi_d         = hi_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        frame_done_d = 1'b0;
        if (stb_q && !stb_rs_q) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = stb_d_q;
            pidx_d      = 2'd0;
            case (stb_d_q)
                CMD_CASET:  state_d = S_CASET;
                CMD_PASET:  state_d = S_PASET;
                CMD_RAMWR: begin
                    state_d = S_RAMWR_HI;
                    x_d     = sc_q;
                    y_d     = sp_q;
                end
                CMD_RAMWRC: state_d = S_RAMWR_HI;
                CMD_SWRESET: begin
                    state_d = S_IDLE;
                    sc_d    = 16'h0;
                    ec_d    = EC_RST;
                    sp_d    = 16'h0;
                    ep_d    = EP_RST;
                end
                default:    state_d = S_SKIP;
            endcase
        end else if (stb_q) begin
            case (state_q)
                S_CASET, S_PASET: begin
                    // The window only changes once all four bytes have arrived.
                    if (pidx_q == 2'd3) begin
                        if (state_q == S_CASET) begin
                            sc_d = par_q[23:8];
                            ec_d = {par_q[7:0], stb_d_q};
                        end else begin
                            sp_d = par_q[23:8];
                            ep_d = {par_q[7:0], stb_d_q};
                        end
                        state_d = S_SKIP;
                    end else begin
                        par_d  = {par_q[15:0], stb_d_q};
                        pidx_d = pidx_q + 2'd1;
                    end
                end
                S_RAMWR_HI: begin
                    hi_d    = stb_d_q;
                    state_d = S_RAMWR_LO;
                end
                S_RAMWR_LO: begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    pix_rgb_d   = {hi_q, stb_d_q};
                    state_d     = S_RAMWR_HI;
                    if (x_q == ec_q) begin
                        x_d = sc_q;
                        if (y_q == ep_q) begin
                            y_d          = sp_q;
                            frame_done_d = 1'b1;
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
        // Panel hardware reset overrides everything, after its synchronizer.
        if (!lrst_sync_q[1]) begin
            state_d      = S_IDLE;
            pidx_d       = 2'd0;
            par_d        = 24'h0;
            sc_d         = 16'h0;
            ec_d         = EC_RST;
            sp_d         = 16'h0;
            ep_d         = EP_RST;
            x_d          = 16'h0;
            y_d          = 16'h0;
            hi_d         = 8'h00;
            cmd_valid_d  = 1'b0;
            cmd_byte_d   = 8'h00;
            pix_valid_d  = 1'b0;
            pix_x_d      = 16'h0;
            pix_y_d      = 16'h0;
            pix_rgb_d    = 16'h0;
            frame_done_d = 1'b0;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_rgb565 = pix_rgb_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ili9341_parallel_8bit_rx.sv
// Bench for ili9341_parallel_8bit_rx: directed vector table, hand sequences for the
// multi-cycle corners, and random bus traffic checked against a byte-list reference model.
module tb_ili9341_parallel_8bit_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lcd_rst_n = 1'b1;
    logic        lcd_cs_n = 1'b1;
    logic        lcd_rs = 1'b0;
    logic        lcd_wr_n = 1'b1;
    logic        lcd_rd_n = 1'b1;
    logic [7:0]  lcd_d = 8'h00;
    logic        cmd_valid, pix_valid, frame_done;
    logic [7:0]  cmd_byte;
    logic [15:0] pix_x, pix_y, pix_rgb565;

    ili9341_parallel_8bit_rx #(.WIDTH(320), .HEIGHT(240)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_rst_n(lcd_rst_n), .lcd_cs_n(lcd_cs_n),
        .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_d(lcd_d),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb565(pix_rgb565), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] rgb;
        logic        fd;
    } pix_t;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         ecmd;
        int         epix;
        pix_t       ep;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int mon_pix_total = 0, mon_fd_total = 0;
    int exp_pix_total = 0, exp_fd_total = 0;
    pix_t mon_pix[$], exp_pix[$];
    logic [7:0] mon_cmd[$], exp_cmd[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (pix_valid) begin
            mon_pix.push_back({pix_x, pix_y, pix_rgb565, frame_done});
            mon_pix_total++;
        end
        if (cmd_valid) mon_cmd.push_back(cmd_byte);
        if (frame_done) begin
            mon_fd_total++;
            chk("frame_done_with_pix", 64'(pix_valid), 64'd1);
        end
    end

    // Reference model: the current command plus the list of parameter bytes received for it.
    localparam int M_IDLE = 0, M_CASET = 1, M_PASET = 2, M_SKIP = 3, M_RAMWR = 4;
    int         m_mode;
    logic [7:0] m_par[$];
    logic [15:0] m_sc, m_ec, m_sp, m_ep, m_x, m_y;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_par.delete();
        m_sc = 0; m_ec = 16'd319; m_sp = 0; m_ep = 16'd239;
        m_x = 0; m_y = 0;
    endtask

    task automatic model_byte(input logic rs, input logic [7:0] d);
        pix_t p;
        if (!rs) begin
            exp_cmd.push_back(d);
            m_par.delete();
            case (d)
                8'h2A: m_mode = M_CASET;
                8'h2B: m_mode = M_PASET;
                8'h2C: begin m_mode = M_RAMWR; m_x = m_sc; m_y = m_sp; end
                8'h3C: m_mode = M_RAMWR;
                8'h01: begin m_mode = M_IDLE; m_sc = 0; m_ec = 16'd319; m_sp = 0; m_ep = 16'd239; end
                default: m_mode = M_SKIP;
            endcase
        end else if (m_mode == M_CASET || m_mode == M_PASET) begin
            m_par.push_back(d);
            if (m_par.size() == 4) begin
                if (m_mode == M_CASET) begin
                    m_sc = {m_par[0], m_par[1]}; m_ec = {m_par[2], m_par[3]};
                end else begin
                    m_sp = {m_par[0], m_par[1]}; m_ep = {m_par[2], m_par[3]};
                end
                m_par.delete();
                m_mode = M_SKIP;
            end
        end else if (m_mode == M_RAMWR) begin
            m_par.push_back(d);
            if (m_par.size() == 2) begin
                p.x = m_x; p.y = m_y; p.rgb = {m_par[0], m_par[1]};
                p.fd = (m_x == m_ec) && (m_y == m_ep);
                exp_pix.push_back(p);
                exp_pix_total++;
                if (p.fd) exp_fd_total++;
                if (m_x == m_ec) begin
                    m_x = m_sc;
                    m_y = (m_y == m_ep) ? m_sp : m_y + 16'd1;
                end else begin
                    m_x = m_x + 16'd1;
                end
                m_par.delete();
            end
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_cs_n = 1'b0; lcd_rs = rs; lcd_d = d; lcd_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr_n = 1'b1;
        repeat (5) @(negedge clk);
        model_byte(rs, d);
    endtask

    task automatic send_px(input logic [15:0] rgb);
        send(1'b1, rgb[15:8]);
        send(1'b1, rgb[7:0]);
    endtask

    task automatic drain(input string name);
        chk({name, "_pixcnt"}, 64'(mon_pix.size()), 64'(exp_pix.size()));
        chk({name, "_cmdcnt"}, 64'(mon_cmd.size()), 64'(exp_cmd.size()));
        while (mon_pix.size() > 0 && exp_pix.size() > 0)
            chk({name, "_pix"}, 64'(mon_pix.pop_front()), 64'(exp_pix.pop_front()));
        while (mon_cmd.size() > 0 && exp_cmd.size() > 0)
            chk({name, "_cmd"}, 64'(mon_cmd.pop_front()), 64'(exp_cmd.pop_front()));
        mon_pix.delete(); exp_pix.delete(); mon_cmd.delete(); exp_cmd.delete();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({name, "_cmd_byte"}, 64'(cmd_byte), 64'd0);
        chk({name, "_pix_valid"}, 64'(pix_valid), 64'd0);
        chk({name, "_pix_xyrgb"}, {16'h0, pix_x, pix_y, pix_rgb565}, 64'd0);
        chk({name, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    function automatic void add(input logic rs, input logic [7:0] d, input int ecmd,
                                input int epix, input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] rgb, input logic fd);
        vec_t v;
        v.rs = rs; v.d = d; v.ecmd = ecmd; v.epix = epix;
        v.ep = {x, y, rgb, fd};
        tbl.push_back(v);
    endfunction

    function automatic void add_c(input logic [7:0] d);
        add(1'b0, d, 1, 0, 0, 0, 0, 1'b0);
    endfunction

    function automatic void add_p(input logic [7:0] d);
        add(1'b1, d, 0, 0, 0, 0, 0, 1'b0);
    endfunction

    function automatic void add_px(input logic [7:0] d, input logic [15:0] x, input logic [15:0] y,
                                   input logic [15:0] rgb, input logic fd);
        add(1'b1, d, 0, 1, x, y, rgb, fd);
    endfunction

    initial begin
        pix_t last;
        logic [7:0] misc_cmds [4];
        misc_cmds[0] = 8'h00; misc_cmds[1] = 8'h29; misc_cmds[2] = 8'h11; misc_cmds[3] = 8'h36;

        add_c(8'h2C); add_p(8'hF8); add_px(8'h00, 0, 0, 16'hF800, 0);
        add_p(8'h07); add_px(8'hE0, 1, 0, 16'h07E0, 0);
        add_c(8'h2A); add_p(8'h00); add_p(8'h0A); add_p(8'h00); add_p(8'h0B);
        add_c(8'h2B); add_p(8'h00); add_p(8'h05); add_p(8'h00); add_p(8'h06);
        add_c(8'h2C);
        add_p(8'h11); add_px(8'h22, 10, 5, 16'h1122, 0);
        add_p(8'h33); add_px(8'h44, 11, 5, 16'h3344, 0);
        add_p(8'h55); add_px(8'h66, 10, 6, 16'h5566, 0);
        add_p(8'h77); add_px(8'h88, 11, 6, 16'h7788, 1);
        add_p(8'h99); add_px(8'hAA, 10, 5, 16'h99AA, 0);
        add_c(8'h01);
        add_c(8'h2A); add_p(8'h00); add_p(8'h0A); add_c(8'h2C);
        add_p(8'hAB); add_px(8'hCD, 0, 0, 16'hABCD, 0);
        add_c(8'h3C); add_p(8'h12); add_px(8'h34, 1, 0, 16'h1234, 0);
        add_c(8'h2C); add_p(8'h56); add_c(8'h00); add_p(8'h78); add_p(8'h9A);

        model_reset();
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_outputs_zero("post_reset");

        for (int i = 0; i < tbl.size(); i++) begin
            mon_pix.delete(); mon_cmd.delete(); exp_pix.delete(); exp_cmd.delete();
            send(tbl[i].rs, tbl[i].d);
            chk($sformatf("vec%0d_cmdcnt", i), 64'(mon_cmd.size()), 64'(tbl[i].ecmd));
            if (tbl[i].ecmd == 1 && mon_cmd.size() == 1)
                chk($sformatf("vec%0d_cmd_byte", i), 64'(mon_cmd[0]), 64'(tbl[i].d));
            chk($sformatf("vec%0d_pixcnt", i), 64'(mon_pix.size()), 64'(tbl[i].epix));
            if (tbl[i].epix == 1 && mon_pix.size() == 1)
                chk($sformatf("vec%0d_pix", i), 64'(mon_pix[0]), 64'(tbl[i].ep));
        end
        mon_pix.delete(); mon_cmd.delete(); exp_pix.delete(); exp_cmd.delete();

        // Half-pixel survives a CS gap.
        send(1'b0, 8'h2C); send(1'b1, 8'h12);
        @(negedge clk); lcd_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        lcd_cs_n = 1'b0;
        send(1'b1, 8'h34);
        chk("cs_gap_pix", 64'(mon_pix.size() > 0 ? mon_pix[0] : '0), 64'({16'd0, 16'd0, 16'h1234, 1'b0}));
        drain("cs_gap");

        // Window at the far corner of the default panel.
        send(1'b0, 8'h2A); send(1'b1, 8'h01); send(1'b1, 8'h3E); send(1'b1, 8'h01); send(1'b1, 8'h3F);
        send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'hEE); send(1'b1, 8'h00); send(1'b1, 8'hEF);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 4; i++) send_px(16'hC000 + 16'(i));
        last = (mon_pix.size() > 0) ? mon_pix[$] : '0;
        chk("corner_last", 64'(last), 64'({16'd319, 16'd239, 16'hC003, 1'b1}));
        drain("corner");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 11);
            case (r)
                0: send(1'b0, 8'h2A);
                1: send(1'b0, 8'h2B);
                2: send(1'b0, 8'h2C);
                3: send(1'b0, 8'h3C);
                4: send(1'b0, ($urandom_range(0, 4) == 0) ? 8'h01 : misc_cmds[$urandom_range(0, 3)]);
                default: begin
                    if ((m_mode == M_CASET || m_mode == M_PASET) && (m_par.size() % 2 == 0))
                        send(1'b1, 8'h00);
                    else if (m_mode == M_CASET || m_mode == M_PASET)
                        send(1'b1, 8'($urandom_range(0, 3)));
                    else
                        send(1'b1, 8'($urandom));
                end
            endcase
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk); lcd_cs_n = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                lcd_cs_n = 1'b0;
            end
            drain("rand");
        end

        // Mid-stream rst_n with a small window and a half-pixel pending.
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h02); send(1'b1, 8'h00); send(1'b1, 8'h03);
        send(1'b0, 8'h2C); send_px(16'hBEEF); send(1'b1, 8'h55);
        drain("pre_rst");
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        send(1'b0, 8'h2C); send_px(16'h0F0F);
        chk("rst_first_pix", 64'(mon_pix.size() > 0 ? mon_pix[0] : '0), 64'({16'd0, 16'd0, 16'h0F0F, 1'b0}));
        drain("post_rst");

        // Default page range: a one-column window walks y through 0..239.
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 241; i++) send_px(16'(i));
        drain("col_sweep");

        // Default column range after SWRESET: a one-page window walks x through 0..319.
        send(1'b0, 8'h01);
        send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 321; i++) send_px(16'h8000 | 16'(i));
        drain("row_sweep");

        // Panel reset pin.
        send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h04); send(1'b1, 8'h00); send(1'b1, 8'h04);
        @(negedge clk); lcd_rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk_outputs_zero("lcd_rst");
        lcd_rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        mon_cmd.delete(); exp_cmd.delete();
        send(1'b0, 8'h2C); send_px(16'h1357); send_px(16'h2468);
        drain("post_lcd_rst");

        chk("total_pix", 64'(mon_pix_total), 64'(exp_pix_total));
        chk("total_frame_done", 64'(mon_fd_total), 64'(exp_fd_total));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
